pb2_fetch_seq: RTL

Instruction fetch sequencer for Processor Board B, directly downstream of the 16-bit program counter. On a fetch request it captures the current PC value onto the address bus, runs one memory read cycle honouring wait states, latches the returned word into the instruction register, and issues the active-low increment strobe (`nincpc`) back to the PC. It replaces ad-hoc microcode sequencing of the fetch cycle with a self-contained handshake block.

---
 rtl/pb2_fetch_pkg.sv | 16 +
 rtl/pb2_fetch_wait_timer.sv | 33 +++
 rtl/pb2_fetch_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pb2_fetch_pkg.sv
// Shared types and widths for the Processor Board B instruction fetch sequencer.
package pb2_fetch_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;
    localparam int BUS_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_LATCH = 3'd4
    } state_t;

endpackage

// File: rtl/pb2_fetch_wait_timer.sv
// Wait-state counter for the fetch sequencer: counts wait cycles and flags when
// the count reaches WAIT_MAX. Only instantiated when PB2_FETCH_TIMEOUT_EN is defined.
module pb2_fetch_wait_timer
    import pb2_fetch_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] count;

    // start loads 1 because the first WAIT cycle is already the first wait state
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(1);
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == LIMIT);

endmodule

// File: rtl/pb2_fetch_seq.sv
// Instruction fetch sequencer: PC -> address bus, one read cycle with wait states,
// word -> ir, nincpc strobe back to the PC. Bus timeout enabled by PB2_FETCH_TIMEOUT_EN.
module pb2_fetch_seq
    import pb2_fetch_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic [BUS_W-1:0] pc,
    output logic             nincpc,
    output logic [BUS_W-1:0] ab,
    output logic             nmem,
    output logic             nr,
    input  logic             nwaiting,
    input  logic [BUS_W-1:0] db,
    output logic [BUS_W-1:0] ir,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    state_t           state, state_nxt;
    logic [BUS_W-1:0] ab_nxt, ir_nxt;

    wait_max_legal: assert property (@(posedge clk) (WAIT_MAX >= 1) && (WAIT_MAX <= 255));

`ifdef PB2_FETCH_TIMEOUT_EN
    logic fault_nxt;
    logic timer_start, timer_en, wait_tc;

    pb2_fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == S_IDLE),
        .start  (timer_start),
        .enable (timer_en),
        .tc     (wait_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) fault <= 1'b0;
        else       fault <= fault_nxt;
    end
`else
    assign fault = 1'b0;
`endif

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_nxt = state;
        ab_nxt    = ab;
        ir_nxt    = ir;
`ifdef PB2_FETCH_TIMEOUT_EN
        fault_nxt   = fault;
        timer_start = 1'b0;
        timer_en    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (fetch) begin
                    state_nxt = S_ADDR;
                    ab_nxt    = pc;
`ifdef PB2_FETCH_TIMEOUT_EN
                    fault_nxt = 1'b0;
`endif
                end
            end
            S_ADDR: state_nxt = S_READ;
            S_READ: begin
                if (nwaiting) begin
                    state_nxt = S_LATCH;
                end else begin
                    state_nxt = S_WAIT;
`ifdef PB2_FETCH_TIMEOUT_EN
                    timer_start = 1'b1;
`endif
                end
            end
            S_WAIT: begin
                if (nwaiting) begin
                    state_nxt = S_LATCH;
                end
`ifdef PB2_FETCH_TIMEOUT_EN
                else if (wait_tc) begin
                    state_nxt = S_IDLE;
                    fault_nxt = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
`endif
            end
            S_LATCH: begin
                ir_nxt    = db;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they line up
    // with the state they belong to and never see a combinational input path.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ab     <= '0;
            ir     <= '0;
            nmem   <= 1'b1;
            nr     <= 1'b1;
            nincpc <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ab     <= ab_nxt;
            ir     <= ir_nxt;
            nmem   <= !(state_nxt inside {S_ADDR, S_READ, S_WAIT});
            nr     <= !(state_nxt inside {S_READ, S_WAIT});
            nincpc <= (state_nxt != S_LATCH);
            busy   <= (state_nxt != S_IDLE);
            done   <= (state_nxt == S_LATCH);
        end
    end

endmodule
